alarm_ringer: RTL
=================

ALARM_RINGER -- requirements
Module: alarm_ringer

Interface
REQ-001 SHALL have parameter RING_SEC, default 60, ring duration in ticks before auto-stop (1..255).
REQ-002 SHALL have parameter SNOOZE_SEC, default 300, snooze interval in ticks (1..1023).
REQ-003 SHALL have parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event (1..3).
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 tick_1hz  in  1  one-clk strobe per second, from the seconds-counter stage.
REQ-007 cur_hour1, cur_hour2, cur_min1, cur_min2, cur_sec1, cur_sec2  in  4 each  running time, BCD, tens/units.
REQ-008 alm_hour1, alm_hour2, alm_min1, alm_min2, alm_sec1, alm_sec2  in  4 each  alarm setting, BCD.
REQ-009 alarm_on  in  1  level; alarm armed.
REQ-010 stop_btn  in  1  debounced one-clk pulse; silence alarm.
REQ-011 snooze_btn  in  1  debounced one-clk pulse; snooze alarm.
REQ-012 tone_512, tone_1k  in  1 each  square-wave tone sources.
REQ-013 beep_out  out  1  gated tone to buzzer.
REQ-014 ringing  out  1  high in RING.
REQ-015 snoozing  out  1  high in SNOOZE.
REQ-016 snooze_cnt  out  2  snoozes used in current event.

Function
REQ-017 Match = alarm_on and all six cur_* digits equal corresponding alm_* digits; evaluated only on clk where tick_1hz=1.
REQ-018 FSM states IDLE, RING, SNOOZE; registered, one-clk transition latency.
REQ-019 IDLE -> RING on tick_1hz with match; ring_cnt cleared, tone_phase cleared, snooze_cnt cleared.
REQ-020 RING: ring_cnt increments per tick_1hz; tone_phase toggles per tick_1hz.
REQ-021 RING: beep_out = tone_512 when tone_phase=0, tone_1k when tone_phase=1; beep_out=0 in IDLE and SNOOZE.
REQ-022 RING -> IDLE when ring_cnt reaches RING_SEC on a tick (auto-stop), or on stop_btn.
REQ-023 RING -> SNOOZE on snooze_btn when snooze_cnt < MAX_SNOOZE; snooze_cnt increments, snz_cnt loaded 0.
REQ-024 snooze_btn in RING with snooze_cnt = MAX_SNOOZE SHALL be ignored.
REQ-025 SNOOZE: snz_cnt increments per tick_1hz; at SNOOZE_SEC -> RING with ring_cnt and tone_phase cleared.
REQ-026 SNOOZE -> IDLE on stop_btn.
REQ-027 Priority per cycle: alarm_on=0 (any state -> IDLE) > stop_btn > snooze_btn > tick-driven transitions.
REQ-028 Match while in RING or SNOOZE SHALL be ignored (no restart).
REQ-029 Counters SHALL saturate-free: widths sized from parameters, no wrap reachable.
REQ-030 snooze_cnt SHALL hold its value in IDLE until next IDLE -> RING.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE, all counters 0, tone_phase 0, beep_out 0, ringing 0, snoozing 0, snooze_cnt 0.
REQ-032 Reset asserted mid-RING or mid-SNOOZE SHALL silence immediately; after release, a new match is needed to ring.

Configuration
REQ-033 Macro ALARM_SNOOZE_EN: defined -> SNOOZE state and REQ-023..026 present.
REQ-034 ALARM_SNOOZE_EN undefined -> snooze_btn ignored, SNOOZE state absent, snoozing and snooze_cnt tied 0; RING exits only via stop, auto-stop, alarm_on=0.

Structure
REQ-035 Shared package timer_pkg SHALL hold the BCD digit typedef (4 bits), the ringer state enum, and tone-phase constants.
REQ-036 One sub-module alarm_match SHALL perform the six-digit BCD compare gated by alarm_on.

Verification
REQ-037 Alarm 07:30:00, alarm_on=1, time reaches 07:30:00 on tick -> ringing=1 next clk, beep_out follows tone_512, then tone_1k after next tick.
REQ-038 Ring with no buttons -> after 60 ticks ringing=0, beep_out=0, state IDLE.
REQ-039 Snooze in RING -> snoozing=1, snooze_cnt=1, beep_out=0; after 300 ticks ringing=1 again; fourth snooze_btn (cnt=3) ignored.
REQ-040 stop_btn and snooze_btn same clk in RING -> IDLE, snooze_cnt unchanged.
REQ-041 alarm_on dropped during SNOOZE -> IDLE next clk; match with alarm_on=0 -> no ring.
REQ-042 rst=0 mid-RING -> beep_out=0 asynchronously; build without ALARM_SNOOZE_EN -> snooze_btn has no effect.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types for the alarm ringer: BCD digit, ringer state and tone-phase values.
package timer_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } ringer_state_t;

  localparam logic TONE_LO = 1'b0;
  localparam logic TONE_HI = 1'b1;

endpackage

// File: rtl/alarm_match.sv
// Six-digit BCD time compare, qualified by the alarm-armed level.
module alarm_match
  import timer_pkg::*;
(
  input  logic alarm_on,
  input  bcd_t cur_hour1,
  input  bcd_t cur_hour2,
  input  bcd_t cur_min1,
  input  bcd_t cur_min2,
  input  bcd_t cur_sec1,
  input  bcd_t cur_sec2,
  input  bcd_t alm_hour1,
  input  bcd_t alm_hour2,
  input  bcd_t alm_min1,
  input  bcd_t alm_min2,
  input  bcd_t alm_sec1,
  input  bcd_t alm_sec2,
  output logic match
);

  assign match = alarm_on &&
                 (cur_hour1 == alm_hour1) && (cur_hour2 == alm_hour2) &&
                 (cur_min1  == alm_min1)  && (cur_min2  == alm_min2)  &&
                 (cur_sec1  == alm_sec1)  && (cur_sec2  == alm_sec2);

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer FSM (IDLE/RING/SNOOZE) with alternating two-tone buzzer output.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_ringer
  import timer_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  bcd_t       cur_hour1,
  input  bcd_t       cur_hour2,
  input  bcd_t       cur_min1,
  input  bcd_t       cur_min2,
  input  bcd_t       cur_sec1,
  input  bcd_t       cur_sec2,
  input  bcd_t       alm_hour1,
  input  bcd_t       alm_hour2,
  input  bcd_t       alm_min1,
  input  bcd_t       alm_min2,
  input  bcd_t       alm_sec1,
  input  bcd_t       alm_sec2,
  input  logic       alarm_on,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  input  logic       tone_512,
  input  logic       tone_1k,
  output logic       beep_out,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_cnt
);

  localparam int RW = $clog2(RING_SEC + 1);

  ringer_state_t   state, state_nx;
  logic [RW-1:0]   ring_cnt, ring_nx;
  logic            tone_phase, phase_nx;
  logic            match;

  alarm_match u_match (
    .alarm_on (alarm_on),
    .cur_hour1(cur_hour1), .cur_hour2(cur_hour2),
    .cur_min1 (cur_min1),  .cur_min2 (cur_min2),
    .cur_sec1 (cur_sec1),  .cur_sec2 (cur_sec2),
    .alm_hour1(alm_hour1), .alm_hour2(alm_hour2),
    .alm_min1 (alm_min1),  .alm_min2 (alm_min2),
    .alm_sec1 (alm_sec1),  .alm_sec2 (alm_sec2),
    .match    (match)
  );

`ifdef ALARM_SNOOZE_EN
  localparam int         SW      = $clog2(SNOOZE_SEC + 1);
  localparam logic [1:0] MAX_SNZ = 2'(MAX_SNOOZE);

  logic [SW-1:0] snz_cnt, snz_nx;
  logic [1:0]    snz_used, used_nx;
`else
  logic unused_snooze;
  assign unused_snooze = snooze_btn ^ ((SNOOZE_SEC + MAX_SNOOZE) > 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      ring_cnt   <= '0;
      tone_phase <= TONE_LO;
`ifdef ALARM_SNOOZE_EN
      snz_cnt    <= '0;
      snz_used   <= '0;
`endif
    end else begin
      state      <= state_nx;
      ring_cnt   <= ring_nx;
      tone_phase <= phase_nx;
`ifdef ALARM_SNOOZE_EN
      snz_cnt    <= snz_nx;
      snz_used   <= used_nx;
`endif
    end
  end

  // Disarming overrides everything; then stop, then snooze, then tick-driven moves.
  always_comb begin
    state_nx = state;
    ring_nx  = ring_cnt;
    phase_nx = tone_phase;
`ifdef ALARM_SNOOZE_EN
    snz_nx   = snz_cnt;
    used_nx  = snz_used;
`endif
    if (!alarm_on) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick_1hz && match) begin
            state_nx = ST_RING;
            ring_nx  = '0;
            phase_nx = TONE_LO;
`ifdef ALARM_SNOOZE_EN
            used_nx  = '0;
`endif
          end
        end
        ST_RING: begin
          if (stop_btn) begin
            state_nx = ST_IDLE;
          end
`ifdef ALARM_SNOOZE_EN
          else if (snooze_btn && (snz_used < MAX_SNZ)) begin
            state_nx = ST_SNOOZE;
            used_nx  = snz_used + 2'd1;
            snz_nx   = '0;
          end
`endif
          else if (tick_1hz) begin
            ring_nx  = ring_cnt + 1'b1;
            phase_nx = ~tone_phase;
            if (ring_nx == RW'(RING_SEC)) state_nx = ST_IDLE;
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (stop_btn) begin
            state_nx = ST_IDLE;
          end else if (tick_1hz) begin
            snz_nx = snz_cnt + 1'b1;
            if (snz_nx == SW'(SNOOZE_SEC)) begin
              state_nx = ST_RING;
              ring_nx  = '0;
              phase_nx = TONE_LO;
            end
          end
        end
`endif
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  assign ringing  = (state == ST_RING);
  assign beep_out = ringing & ((tone_phase == TONE_HI) ? tone_1k : tone_512);

`ifdef ALARM_SNOOZE_EN
  assign snoozing   = (state == ST_SNOOZE);
  assign snooze_cnt = snz_used;
`else
  assign snoozing   = 1'b0;
  assign snooze_cnt = 2'b00;
`endif

endmodule
